// File: rtl/knn_pkg.sv
// Shared types, defaults and width helpers for the streaming KNN top-K selector.
package knn_pkg;

  localparam int unsigned KDefault     = 8;
  localparam int unsigned WDefault     = 16;
  localparam int unsigned TypeWDefault = 3;

  typedef enum logic [1:0] {StLoad, StVote, StDone} state_e;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3, clog2(9) = 4.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Number of distinct classes representable by a type field.
  function automatic int unsigned nclass(input int unsigned type_w);
    return 32'd1 << type_w;
  endfunction

  localparam int unsigned CntWDefault    = clog2(KDefault + 1);
  localparam int unsigned NClassDefault  = nclass(TypeWDefault);

endpackage

// File: rtl/topk_insert_cell.sv
// One slot of the sorted top-K array: holds a (distance, type) entry and decides
// whether a new sample beats it; shifting is driven by the upstream slot's verdict.
module topk_insert_cell
  import knn_pkg::*;
#(
  parameter int unsigned W      = WDefault,
  parameter int unsigned TYPE_W = TypeWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              accept_i,
  input  logic              clear_i,
  input  logic              asc_i,
  input  logic [W-1:0]      new_dist_i,
  input  logic [TYPE_W-1:0] new_type_i,
  input  logic              up_valid_i,
  input  logic [W-1:0]      up_dist_i,
  input  logic [TYPE_W-1:0] up_type_i,
  input  logic              up_better_i,
  output logic              valid_o,
  output logic [W-1:0]      dist_o,
  output logic [TYPE_W-1:0] type_o,
  output logic              better_o
);

  logic              valid_q, valid_d;
  logic [W-1:0]      dist_q, dist_d;
  logic [TYPE_W-1:0] type_q, type_d;

  // Strict compare so equal distances never displace an existing entry.
  assign better_o = !valid_q | (asc_i ? (new_dist_i < dist_q) : (new_dist_i > dist_q));

  // Empty slots present zeros so shifted-in bubbles carry clean contents.
  assign valid_o = valid_q;
  assign dist_o  = valid_q ? dist_q : '0;
  assign type_o  = valid_q ? type_q : '0;

  // Next-state: clear on result handoff, else shift-from-upstream or take the new sample.
  always_comb begin
    valid_d = valid_q;
    dist_d  = dist_q;
    type_d  = type_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (accept_i && better_o) begin
      if (up_better_i) begin
        valid_d = up_valid_i;
        dist_d  = up_dist_i;
        type_d  = up_type_i;
      end else begin
        valid_d = 1'b1;
        dist_d  = new_dist_i;
        type_d  = new_type_i;
      end
    end
  end

  // Slot register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      dist_q  <= '0;
      type_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dist_q  <= dist_d;
      type_q  <= type_d;
    end
  end

endmodule

// File: rtl/knn_topk_stream.sv
// Streaming top-K selector: single-cycle sorted insertion per accepted sample, then a
// one-class-per-cycle majority vote, then a held result until the consumer takes it.
module knn_topk_stream
  import knn_pkg::*;
#(
  parameter int unsigned K      = KDefault,
  parameter int unsigned W      = WDefault,
  parameter int unsigned TYPE_W = TypeWDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_dist,
  input  logic [TYPE_W-1:0]          in_type,
  input  logic                       in_last,
  input  logic                       ascending,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W*K-1:0]             out_dist,
  output logic [TYPE_W*K-1:0]        out_type,
  output logic [clog2(K+1)-1:0]      out_count,
  output logic [TYPE_W-1:0]          out_class,
  output logic [clog2(K+1)-1:0]      out_votes
);

  localparam int unsigned CntW   = clog2(K + 1);
  localparam int unsigned NClass = nclass(TYPE_W);

  state_e            state_q, state_d;
  logic              asc_q, asc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TYPE_W-1:0] vote_c_q, vote_c_d;
  logic [TYPE_W-1:0] best_class_q, best_class_d;
  logic [CntW-1:0]   best_votes_q, best_votes_d;

  logic              accept, clear, asc_eff;
  logic [CntW-1:0]   votes;

  logic              cell_valid [K];
  logic [W-1:0]      cell_dist  [K];
  logic [TYPE_W-1:0] cell_type  [K];
  logic              better     [K];
  logic              up_valid   [K];
  logic [W-1:0]      up_dist    [K];
  logic [TYPE_W-1:0] up_type    [K];
  logic              up_better  [K];

  // rst gates ready so nothing is accepted while reset is held.
  assign in_ready  = (state_q == StLoad) & rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign clear     = out_valid & out_ready;
  // Direction is taken live on the frame's first sample, latched afterwards.
  assign asc_eff   = (count_q == '0) ? ascending : asc_q;

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign up_valid[i]  = 1'b0;
      assign up_dist[i]   = '0;
      assign up_type[i]   = '0;
      assign up_better[i] = 1'b0;
    end else begin : g_link
      assign up_valid[i]  = cell_valid[i-1];
      assign up_dist[i]   = cell_dist[i-1];
      assign up_type[i]   = cell_type[i-1];
      assign up_better[i] = better[i-1];
    end

    topk_insert_cell #(
      .W      (W),
      .TYPE_W (TYPE_W)
    ) u_cell (
      .clk_i       (clk),
      .rst_ni      (rst),
      .accept_i    (accept),
      .clear_i     (clear),
      .asc_i       (asc_eff),
      .new_dist_i  (in_dist),
      .new_type_i  (in_type),
      .up_valid_i  (up_valid[i]),
      .up_dist_i   (up_dist[i]),
      .up_type_i   (up_type[i]),
      .up_better_i (up_better[i]),
      .valid_o     (cell_valid[i]),
      .dist_o      (cell_dist[i]),
      .type_o      (cell_type[i]),
      .better_o    (better[i])
    );

    assign out_dist[i*W +: W]           = out_valid ? cell_dist[i] : '0;
    assign out_type[i*TYPE_W +: TYPE_W] = out_valid ? cell_type[i] : '0;
  end

  assign out_count = out_valid ? count_q      : '0;
  assign out_class = out_valid ? best_class_q : '0;
  assign out_votes = out_valid ? best_votes_q : '0;

  // Popcount of valid slots whose type matches the class under vote.
  always_comb begin
    votes = '0;
    for (int i = 0; i < K; i++) begin
      if (cell_valid[i] && (cell_type[i] == vote_c_q)) votes = votes + CntW'(1);
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    asc_d        = asc_q;
    count_d      = count_q;
    vote_c_d     = vote_c_q;
    best_class_d = best_class_q;
    best_votes_d = best_votes_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (count_q == '0) asc_d = ascending;
          if (count_q != CntW'(K)) count_d = count_q + CntW'(1);
          if (in_last) begin
            state_d      = StVote;
            vote_c_d     = '0;
            best_class_d = '0;
            best_votes_d = '0;
          end
        end
      end
      StVote: begin
        // Strict greater-than keeps the lowest class index on ties.
        if (votes > best_votes_q) begin
          best_votes_d = votes;
          best_class_d = vote_c_q;
        end
        if (vote_c_q == TYPE_W'(NClass - 1)) state_d = StDone;
        else vote_c_d = vote_c_q + TYPE_W'(1);
      end
      StDone: begin
        if (out_ready) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Control and vote registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StLoad;
      asc_q        <= 1'b0;
      count_q      <= '0;
      vote_c_q     <= '0;
      best_class_q <= '0;
      best_votes_q <= '0;
    end else begin
      state_q      <= state_d;
      asc_q        <= asc_d;
      count_q      <= count_d;
      vote_c_q     <= vote_c_d;
      best_class_q <= best_class_d;
      best_votes_q <= best_votes_d;
    end
  end

endmodule
